// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver with 16x oversampling and 3-sample majority vote.
//   Clk        in   system clock
//   Reset      in   asynchronous active-high reset
//   Baud_set   in   [2:0] rate select (0:9600 1:19200 2:38400 3:57600 4..7:115200), latched at start
//   uart_rx    in   serial line, idle high, asynchronous to Clk
//   Data       out  [7:0] last correctly framed byte, held until the next good frame
//   Rx_done    out  1-cycle strobe, Data newly valid
//   Frame_err  out  1-cycle strobe, stop bit voted 0
module uart_byte_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [2:0] Baud_set,
    input  logic       uart_rx,
    output logic [7:0] Data,
    output logic       Rx_done,
    output logic       Frame_err
);

    // Subsample dividers, one per supported rate
    localparam int unsigned DIV_9600   = CLK_FREQ / (9600 * 16) - 1;
    localparam int unsigned DIV_19200  = CLK_FREQ / (19200 * 16) - 1;
    localparam int unsigned DIV_38400  = CLK_FREQ / (38400 * 16) - 1;
    localparam int unsigned DIV_57600  = CLK_FREQ / (57600 * 16) - 1;
    localparam int unsigned DIV_115200 = CLK_FREQ / (115200 * 16) - 1;
    // Slowest rate sets the counter width
    localparam int unsigned DIV_W      = (DIV_9600 < 2) ? 1 : $clog2(DIV_9600 + 1);
    localparam int unsigned SC_W       = 4;
    localparam int unsigned BIT_W      = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HI
    } state_e;

    state_e             state_q,     state_d;
    logic               sync1_q,     sync1_d;
    logic               sync2_q,     sync2_d;
    logic               edge_q,      edge_d;
    logic [2:0]         baud_q,      baud_d;
    logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
    logic [SC_W-1:0]    sc_q,        sc_d;
    logic [2:0]         samp_q,      samp_d;
    logic               vote_pend_q, vote_pend_d;
    logic [BIT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [7:0]         shift_q,     shift_d;
    logic [7:0]         data_q,      data_d;
    logic               rx_done_q,   rx_done_d;
    logic               frame_err_q, frame_err_d;

    logic               start_det;
    logic               tick;
    logic               bit_end;
    logic               vote;
    logic [DIV_W-1:0]   div_sel;

    function automatic logic [DIV_W-1:0] div_for(input logic [2:0] code);
        case (code)
            3'd0:    return DIV_W'(DIV_9600);
            3'd1:    return DIV_W'(DIV_19200);
            3'd2:    return DIV_W'(DIV_38400);
            3'd3:    return DIV_W'(DIV_57600);
            default: return DIV_W'(DIV_115200);
        endcase
    endfunction

    // State and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            edge_q      <= 1'b1;
            baud_q      <= '0;
            div_cnt_q   <= '0;
            sc_q        <= '0;
            samp_q      <= '0;
            vote_pend_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            edge_q      <= edge_d;
            baud_q      <= baud_d;
            div_cnt_q   <= div_cnt_d;
            sc_q        <= sc_d;
            samp_q      <= samp_d;
            vote_pend_q <= vote_pend_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state, oversampling and output logic
    always_comb begin
        state_d     = state_q;
        sync1_d     = uart_rx;
        sync2_d     = sync1_q;
        edge_d      = sync2_q;
        baud_d      = baud_q;
        div_cnt_d   = div_cnt_q;
        sc_d        = sc_q;
        samp_d      = samp_q;
        vote_pend_d = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        start_det = (state_q == S_IDLE) && edge_q && !sync2_q;
        div_sel   = div_for(baud_q);
        tick      = (state_q != S_IDLE) && (div_cnt_q == div_sel);
        bit_end   = tick && (sc_q == SC_W'(15));
        vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

        // Divider and subsample counter are held clear while idle so a frame starts aligned
        if (state_q == S_IDLE) begin
            div_cnt_d = '0;
            sc_d      = '0;
        end else if (tick) begin
            div_cnt_d = '0;
            sc_d      = sc_q + SC_W'(1);
            if ((sc_q == SC_W'(6)) || (sc_q == SC_W'(7)) || (sc_q == SC_W'(8))) begin
                samp_d = {samp_q[1:0], sync2_q};
            end
            // Vote is consumed on the clock after the last sample lands
            if (sc_q == SC_W'(8)) begin
                vote_pend_d = 1'b1;
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_det) begin
                    state_d   = S_START;
                    baud_d    = Baud_set;
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                // A start bit that votes high was a glitch
                if (vote_pend_q && vote) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (vote_pend_q) begin
                    shift_d = {vote, shift_q[7:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == BIT_W'(7)) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_STOP: begin
                // Decide at mid-stop so a back-to-back start edge is not missed
                if (vote_pend_q) begin
                    if (vote) begin
                        data_d    = shift_q;
                        rx_done_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                // A held break yields a single error, not one per frame time
                if (sync2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Data      = data_q;
    assign Rx_done   = rx_done_q;
    assign Frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: self-checking bench for uart_byte_rx. Frames are built bit by bit
// from the byte value; expected results come from a byte-level model of 8N1 framing.
module tb_uart_byte_rx;

    localparam int unsigned CLK_FREQ = 8_000_000;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] Baud_set = 3'd4;
    logic       uart_rx = 1'b1;
    logic [7:0] Data;
    logic       Rx_done;
    logic       Frame_err;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned fall_cyc = 0;
    int unsigned done_cyc = 0;
    logic [7:0]  rx_q[$];
    int          ferr_cnt = 0;
    int          overlap_total = 0;
    logic [7:0]  model_data = 8'h00;

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Baud_set  (Baud_set),
        .uart_rx   (uart_rx),
        .Data      (Data),
        .Rx_done   (Rx_done),
        .Frame_err (Frame_err)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Observer: record strobes on the falling edge
    always @(negedge Clk) begin
        if (!Reset) begin
            if (Rx_done) begin
                rx_q.push_back(Data);
                done_cyc = cyc;
            end
            if (Frame_err) ferr_cnt = ferr_cnt + 1;
            if (Rx_done && Frame_err) overlap_total = overlap_total + 1;
        end
    end

    // Clocks per bit for a rate code, from the nominal rate table
    function automatic int unsigned bit_clks(input logic [2:0] code);
        int unsigned rate;
        case (code)
            3'd0:    rate = 9600;
            3'd1:    rate = 19200;
            3'd2:    rate = 38400;
            3'd3:    rate = 57600;
            default: rate = 115200;
        endcase
        return (CLK_FREQ / (rate * 16)) * 16;
    endfunction

    function automatic logic [7:0] got(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    task automatic clear_mon();
        rx_q.delete();
        ferr_cnt = 0;
    endtask

    task automatic idle(input int unsigned n);
        uart_rx = 1'b1;
        repeat (n) @(negedge Clk);
    endtask

    task automatic drive_frame(input logic [7:0] b, input int unsigned bc, input logic stop);
        uart_rx  = 1'b0;
        fall_cyc = cyc;
        repeat (bc) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (bc) @(negedge Clk);
        end
        uart_rx = stop;
        repeat (bc) @(negedge Clk);
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge Clk);
        checks++; if (Data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp %h", Data, 8'h00); end
        checks++; if (Rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done got %b exp 0", Rx_done); end
        checks++; if (Frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", Frame_err); end
        Reset = 1'b0;
        model_data = 8'h00;
        idle(10);
    endtask

    task automatic test_single();
        int unsigned bc = bit_clks(3'd4);
        int lat, exp_lat, tol;
        clear_mon();
        Baud_set = 3'd4;
        drive_frame(8'h57, bc, 1'b1);
        idle(2 * bc);
        model_data = 8'h57;
        exp_lat = int'((19 * bc) / 2 + 3);
        tol     = int'(bc / 8 + 4);
        lat     = int'(done_cyc - fall_cyc);
        checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", rx_q.size()); end
        checks++; if (got(0) !== 8'h57) begin errors++; $display("FAIL single_byte got %h exp %h", got(0), 8'h57); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL single_ferr got %0d exp 0", ferr_cnt); end
        checks++; if (Data !== model_data) begin errors++; $display("FAIL single_data_hold got %h exp %h", Data, model_data); end
        checks++;
        if (lat < exp_lat - tol || lat > exp_lat + tol) begin
            errors++; $display("FAIL single_latency got %0d exp %0d +/- %0d", lat, exp_lat, tol);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned bc = bit_clks(3'd4);
        clear_mon();
        Baud_set = 3'd4;
        drive_frame(8'h57, bc, 1'b1);
        drive_frame(8'h75, bc, 1'b1);
        idle(2 * bc);
        model_data = 8'h75;
        checks++; if (rx_q.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", rx_q.size()); end
        checks++; if (got(0) !== 8'h57) begin errors++; $display("FAIL b2b_first got %h exp %h", got(0), 8'h57); end
        checks++; if (got(1) !== 8'h75) begin errors++; $display("FAIL b2b_second got %h exp %h", got(1), 8'h75); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL b2b_ferr got %0d exp 0", ferr_cnt); end
    endtask

    task automatic test_glitch();
        int unsigned bc = bit_clks(3'd4);
        clear_mon();
        Baud_set = 3'd4;
        uart_rx = 1'b0;
        repeat (bc / 4) @(negedge Clk);
        idle(2 * bc);
        checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL glitch_no_done got %0d exp 0", rx_q.size()); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL glitch_no_ferr got %0d exp 0", ferr_cnt); end
        checks++; if (Data !== model_data) begin errors++; $display("FAIL glitch_data_hold got %h exp %h", Data, model_data); end
        drive_frame(8'hA5, bc, 1'b1);
        idle(2 * bc);
        model_data = 8'hA5;
        checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL glitch_next_count got %0d exp 1", rx_q.size()); end
        checks++; if (got(0) !== 8'hA5) begin errors++; $display("FAIL glitch_next_byte got %h exp %h", got(0), 8'hA5); end
    endtask

    task automatic test_frame_err();
        int unsigned bc = bit_clks(3'd4);
        logic [7:0] b;
        clear_mon();
        Baud_set = 3'd4;
        drive_frame(8'h3C, bc, 1'b0);
        uart_rx = 1'b0;
        repeat (2 * bc) @(negedge Clk);
        idle(2 * bc);
        checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", ferr_cnt); end
        checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL ferr_no_done got %0d exp 0", rx_q.size()); end
        checks++; if (Data !== model_data) begin errors++; $display("FAIL ferr_data_hold got %h exp %h", Data, model_data); end
        clear_mon();
        b = 8'($urandom);
        drive_frame(b, bc, 1'b1);
        idle(2 * bc);
        model_data = b;
        checks++; if (got(0) !== b) begin errors++; $display("FAIL ferr_recover_byte got %h exp %h", got(0), b); end
        checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL ferr_recover_count got %0d exp 1", rx_q.size()); end
    endtask

    task automatic test_baud_rates();
        int unsigned bc0 = bit_clks(3'd0);
        int unsigned bc7 = bit_clks(3'd7);
        int unsigned bc3 = bit_clks(3'd3);
        clear_mon();
        Baud_set = 3'd0;
        drive_frame(8'hA5, bc0, 1'b1);
        idle(2 * bc0);
        Baud_set = 3'd7;
        drive_frame(8'h5A, bc7, 1'b1);
        idle(2 * bc7);
        checks++; if (got(0) !== 8'hA5) begin errors++; $display("FAIL baud9600_byte got %h exp %h", got(0), 8'hA5); end
        checks++; if (got(1) !== 8'h5A) begin errors++; $display("FAIL baud7_byte got %h exp %h", got(1), 8'h5A); end
        // Rate select changes mid-frame; the frame keeps its latched rate
        clear_mon();
        Baud_set = 3'd3;
        fork
            drive_frame(8'hC3, bc3, 1'b1);
            begin
                repeat (3 * bc3) @(negedge Clk);
                Baud_set = 3'd0;
            end
        join
        idle(2 * bc3);
        model_data = 8'hC3;
        checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL baud_switch_count got %0d exp 1", rx_q.size()); end
        checks++; if (got(0) !== 8'hC3) begin errors++; $display("FAIL baud_switch_byte got %h exp %h", got(0), 8'hC3); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL baud_switch_ferr got %0d exp 0", ferr_cnt); end
        Baud_set = 3'd4;
    endtask

    task automatic test_reset_mid_frame();
        int unsigned bc = bit_clks(3'd4);
        clear_mon();
        Baud_set = 3'd4;
        uart_rx = 1'b0;
        repeat (bc) @(negedge Clk);
        uart_rx = 1'b1;
        repeat (3 * bc + bc / 2) @(negedge Clk);
        Reset = 1'b1;
        #1;
        checks++; if (Data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h exp %h", Data, 8'h00); end
        checks++; if (Rx_done !== 1'b0 || Frame_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_strobes got %b%b exp 00", Rx_done, Frame_err);
        end
        @(negedge Clk);
        repeat (4) @(negedge Clk);
        Reset = 1'b0;
        model_data = 8'h00;
        idle(12 * bc);
        checks++; if (rx_q.size() !== 0 || ferr_cnt !== 0) begin
            errors++; $display("FAIL rst_mid_no_strobe got %0d/%0d exp 0/0", rx_q.size(), ferr_cnt);
        end
        drive_frame(8'h12, bc, 1'b1);
        idle(2 * bc);
        model_data = 8'h12;
        checks++; if (got(0) !== 8'h12) begin errors++; $display("FAIL rst_mid_next_byte got %h exp %h", got(0), 8'h12); end
        checks++; if (Data !== model_data) begin errors++; $display("FAIL rst_mid_next_data got %h exp %h", Data, model_data); end
    endtask

    task automatic test_random();
        logic [7:0]  exp_q[$];
        int          exp_ferr = 0;
        logic [2:0]  code;
        logic [7:0]  b;
        logic        stop;
        int unsigned bc;
        clear_mon();
        for (int n = 0; n < 6; n++) begin
            code = 3'($urandom_range(1, 7));
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            bc   = bit_clks(code);
            Baud_set = code;
            drive_frame(b, bc, stop);
            if (stop) begin
                exp_q.push_back(b);
                model_data = b;
                idle($urandom_range(0, int'(bc)));
            end else begin
                exp_ferr++;
                idle(bc);
            end
        end
        idle(2 * bit_clks(3'd1));
        checks++; if (rx_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL rand_count got %0d exp %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got(i) !== exp_q[i]) begin
                errors++; $display("FAIL rand_byte%0d got %h exp %h", i, got(i), exp_q[i]);
            end
        end
        checks++; if (ferr_cnt !== exp_ferr) begin errors++; $display("FAIL rand_ferr got %0d exp %0d", ferr_cnt, exp_ferr); end
        checks++; if (Data !== model_data) begin errors++; $display("FAIL rand_data_hold got %h exp %h", Data, model_data); end
    endtask

    task automatic test_exclusive();
        checks++; if (overlap_total !== 0) begin
            errors++; $display("FAIL strobe_overlap got %0d exp 0", overlap_total);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_baud_rates();
        test_reset_mid_frame();
        test_random();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
